audio_serial_rx: RTL and testbench
==================================

// Module: audio_serial_rx
// PURPOSE
//  Receiver/deserializer for the serial audio stream our speaker_control transmitter produces
//  (audio_lrck + audio_sdin, internal-serial-clock mode, audio_sck tied high).
//  - Recovers bit timing from lrck edges plus a local counter.
//  - Outputs 16-bit left/right sample pairs with a one-cycle valid strobe.
//  - Used for loopback self-test of the audio path and as the capture front-end for a line-in DAC/ADC.
// PARAMETERS
//  SLOT_CYCLES  16   clk cycles per serial bit slot (transmitter: clk_cnt[8:4] slot, clk_cnt[3:0] phase)
//  SAMPLE_PHASE 8    phase within a slot at which sdin is sampled (mid-bit)
// PORTS
//  clk           in   1   system clock; same clock as the transmitter
//  rst           in   1   reset; asynchronous, active-high
//  audio_lrck    in   1   word-select; low = first half-frame, high = second half-frame
//  audio_sdin    in   1   serial data
//  sample_left   out  16  last complete left word (two's complement)
//  sample_right  out  16  last complete right word
//  sample_valid  out  1   1-cycle pulse when sample_left/right update together
//  locked        out  1   1 while frame timing is tracked
//  frame_err     out  1   1-cycle pulse on lrck timing violation
// BEHAVIOUR
//  - Reset values: all outputs 0, FSM in HUNT, counters and shift registers 0.
//  - lrck and sdin each pass through a 2-flop synchronizer. Edges are detected on the synced lrck
//    against its 1-cycle-delayed copy.
//  - cyc[8:0] is the frame counter:
//    - Loaded to 0 in the cycle a synced falling edge is detected; otherwise increments each cycle, wrapping 511->0.
//    - slot = cyc[8:4]; phase = cyc[3:0].
//  - FSM HUNT:
//    - Ignores data and rising edges.
//    - On a falling edge: go LOCKED, cyc<=0, have_left<=0.
//  - FSM LOCKED, checked every cycle:
//    - Rising edge while cyc!=255 -> violation.
//    - Falling edge while cyc!=511 -> violation.
//    - cyc==511 with no falling edge -> violation.
//    - cyc==255 with no rising edge -> violation.
//    - On violation: frame_err pulses the next cycle, FSM goes HUNT, partial words and have_left are discarded.
//      sample_* outputs hold their old values.
//    - A falling edge detected in the same cycle as a violation does NOT relock that cycle.
//      Relock happens only on a later falling edge.
//  - Bit mapping per frame, with sdin sampled at phase==SAMPLE_PHASE:
//    - slot 0: LSB (bit0) of the PREVIOUS frame's right word.
//    - slots 1..15: left[15:1]; slot 16: left[0].
//    - slots 17..31: right[15:1].
//    - Shift-in is MSB-first into a 16-bit shift register.
//  - Word completion:
//    - Slot 16 sample completes left: left_buf<=word, have_left<=1.
//    - Slot 0 sample completes right. If have_left==1, then next cycle: sample_left<=left_buf,
//      sample_right<=word, sample_valid=1.
//    - The slot-0 bit of the first frame after lock belongs to a pre-lock word and is dropped
//      (have_left==0), so no valid is produced for it.
//  - Latency: sample_valid rises 1 clk after the cyc==8 sampling cycle. One pair per 512 clk.
//    The first valid arrives in frame 2 after lock.
//  - locked = (state==LOCKED), registered. It drops in the same cycle frame_err pulses.
//  - rst asserted mid-frame returns everything to reset values immediately. No valid is emitted
//    for the interrupted frame.
// TESTING
//  1. Loopback from speaker_control, left=16'h1234, right=16'hABCD. Expected:
//     - locked=1 within 512 clk of the first lrck fall.
//     - First sample_valid carries 1234/ABCD; one valid every 512 clk thereafter.
//  2. Loopback with volume-5 square waves (+1000 / -1000). Expected: sample_left toggles between
//     16'h03E8 and 16'hFC18, and the sign is preserved.
//  3. Stretch one lrck high phase to 300 clk. Expected:
//     - frame_err pulses once (at cyc 511 with no fall), locked=0.
//     - Relock on the next fall; no valid is emitted with corrupted data.
//  4. Hold lrck constant from reset for 2000 clk. Expected: locked=0, sample_valid never asserted,
//     outputs remain 0.
//  5. Assert rst at slot 10 of a locked frame. Expected: all outputs 0 within 1 clk. After release,
//     the first valid comes only after a full relock plus one frame.
//  6. Flip sdin in the last 2 cycles of every slot (phase 14-15). Expected: data still received
//     correctly, confirming mid-bit sampling.

Source files
------------

// File: rtl/audio_serial_rx.sv
// Deserializer for the lrck/sdin audio stream: tracks frame timing from lrck edges and a local
// cycle counter, samples sdin mid-bit and emits 16-bit left/right pairs with a valid strobe.
module audio_serial_rx #(
  parameter int unsigned SLOT_CYCLES  = 16,
  parameter int unsigned SAMPLE_PHASE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        audio_lrck,
  input  logic        audio_sdin,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  output logic        locked,
  output logic        frame_err
);

  localparam int unsigned PhaseW = $clog2(SLOT_CYCLES);
  localparam int unsigned CycW   = PhaseW + 5;

  localparam logic [CycW-1:0]   CycHalf  = CycW'(16 * SLOT_CYCLES - 1);
  localparam logic [CycW-1:0]   CycLast  = CycW'(32 * SLOT_CYCLES - 1);
  localparam logic [PhaseW-1:0] SamplePh = PhaseW'(SAMPLE_PHASE);

  localparam logic [0:0] StHunt   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic            lrck_s1_q, lrck_s2_q, lrck_d_q;
  logic            sdin_s1_q, sdin_s2_q;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [0:0]      state_q, state_d;
  // Only 15 bits are stored; the 16th bit of a word is the live sdin sample.
  logic [14:0]     shift_q, shift_d;
  logic [15:0]     left_buf_q, left_buf_d;
  logic            have_left_q, have_left_d;
  logic [15:0]     sample_left_q, sample_left_d;
  logic [15:0]     sample_right_q, sample_right_d;
  logic            sample_valid_q, sample_valid_d;
  logic            locked_q, locked_d;
  logic            frame_err_q, frame_err_d;

  logic        fall, rise, sample_now, violation;
  logic [4:0]  slot;
  logic [15:0] word;

  assign fall       = lrck_d_q & ~lrck_s2_q;
  assign rise       = ~lrck_d_q & lrck_s2_q;
  assign slot       = cyc_q[CycW-1:PhaseW];
  assign sample_now = (cyc_q[PhaseW-1:0] == SamplePh);
  assign word       = {shift_q, sdin_s2_q};

  assign violation = (state_q == StLocked) &&
                     ((rise && (cyc_q != CycHalf)) || (fall && (cyc_q != CycLast)) ||
                      ((cyc_q == CycLast) && !fall) || ((cyc_q == CycHalf) && !rise));

  always_comb begin
    state_d        = state_q;
    cyc_d          = fall ? '0 : cyc_q + 1'b1;
    shift_d        = shift_q;
    left_buf_d     = left_buf_q;
    have_left_d    = have_left_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    sample_valid_d = 1'b0;
    frame_err_d    = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (fall) begin
          state_d     = StLocked;
          have_left_d = 1'b0;
        end
      end
      StLocked: begin
        if (violation) begin
          // A fall coinciding with the violation does not relock; wait for the next one.
          state_d     = StHunt;
          frame_err_d = 1'b1;
          have_left_d = 1'b0;
          shift_d     = '0;
        end else if (sample_now) begin
          shift_d = word[14:0];
          if (slot == 5'd16) begin
            left_buf_d  = word;
            have_left_d = 1'b1;
          end else if (slot == 5'd0) begin
            have_left_d = 1'b0;
            if (have_left_q) begin
              sample_left_d  = left_buf_q;
              sample_right_d = word;
              sample_valid_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StHunt;
    endcase
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lrck_s1_q      <= 1'b0;
      lrck_s2_q      <= 1'b0;
      lrck_d_q       <= 1'b0;
      sdin_s1_q      <= 1'b0;
      sdin_s2_q      <= 1'b0;
      cyc_q          <= '0;
      state_q        <= StHunt;
      shift_q        <= '0;
      left_buf_q     <= '0;
      have_left_q    <= 1'b0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      lrck_s1_q      <= audio_lrck;
      lrck_s2_q      <= lrck_s1_q;
      lrck_d_q       <= lrck_s2_q;
      sdin_s1_q      <= audio_sdin;
      sdin_s2_q      <= sdin_s1_q;
      cyc_q          <= cyc_d;
      state_q        <= state_d;
      shift_q        <= shift_d;
      left_buf_q     <= left_buf_d;
      have_left_q    <= have_left_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      locked_q       <= locked_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;
  assign locked       = locked_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_audio_serial_rx.sv
// Bench for audio_serial_rx: a frame-level transmitter model drives scenario records from a table
// and a queue of sent word pairs is matched against every sample_valid.
module tb_audio_serial_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        audio_lrck = 1'b1;
  logic        audio_sdin = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, locked, frame_err;

  audio_serial_rx #(.SLOT_CYCLES(16), .SAMPLE_PHASE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .audio_lrck   (audio_lrck),
    .audio_sdin   (audio_sdin),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // mode: 0 random words, 1 fixed 1234/ABCD, 2 +/-1000 square wave
  typedef struct packed {
    int   mode;
    int   n;
    int   stretch;
    int   abort;
    logic flip;
    int   exp_valid;
    int   exp_err;
  } scen_t;

  scen_t       tbl[7];
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];
  int          checks = 0;
  int          failures = 0;
  int          valid_seen = 0;
  int          err_seen = 0;
  longint      cycle = 0;
  longint      last_valid = 0;
  bit          spacing_ok = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe();
    logic [15:0] el, er;
    if (rst) begin
      spacing_ok = 1'b0;
      return;
    end
    if (sample_valid) begin
      valid_seen++;
      if (exp_l.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got %h/%h expected no valid", sample_left, sample_right);
      end else begin
        el = exp_l.pop_front();
        er = exp_r.pop_front();
        check("pair", {32'h0, sample_left, sample_right}, {32'h0, el, er});
      end
      if (spacing_ok) check("valid_spacing", cycle - last_valid, 64'd512);
      last_valid = cycle;
      spacing_ok = 1'b1;
    end
    if (frame_err) begin
      err_seen++;
      spacing_ok = 1'b0;
      check("locked_drops_with_err", {63'h0, locked}, 64'h0);
    end
  endtask

  // Observe at the falling edge, then return just after the next rising edge.
  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic run_scenario(input scen_t s);
    int          vb, eb, slot, hi_len;
    logic [15:0] l, r, prev_r;
    logic        b;
    bit          aborted;
    audio_lrck = 1'b1;
    audio_sdin = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("reset_state", {28'h0, sample_left, sample_right, sample_valid, locked, frame_err},
          64'h0);
    rst = 1'b0;
    vb = valid_seen;
    eb = err_seen;
    prev_r = 16'h0;
    aborted = 1'b0;
    repeat (20) step();
    for (int f = 0; f < s.n && !aborted; f++) begin
      case (s.mode)
        1: begin l = 16'h1234; r = 16'hABCD; end
        2: begin
          l = f[0] ? 16'hFC18 : 16'h03E8;
          r = f[0] ? 16'h03E8 : 16'hFC18;
        end
        default: begin l = 16'($urandom); r = 16'($urandom); end
      endcase
      // A frame's pair appears during the next frame, unless that frame never arrives intact.
      if (f < s.n - 1 && f != s.stretch && (s.abort < 0 || f < s.abort)) begin
        exp_l.push_back(l);
        exp_r.push_back(r);
      end
      hi_len = (f == s.stretch) ? 300 : 256;
      for (int c = 0; c < 256 + hi_len; c++) begin
        step();
        if (f == s.abort && c == 160) begin
          rst = 1'b1;
          #1;
          check("async_reset_outputs",
                {28'h0, sample_left, sample_right, sample_valid, locked, frame_err}, 64'h0);
          aborted = 1'b1;
          break;
        end
        if (f == 0 && c == 20) check("locked_after_first_fall", {63'h0, locked}, 64'h1);
        audio_lrck = (c >= 256);
        slot = c / 16;
        if (c >= 512) b = 1'b0;
        else if (slot == 0) b = prev_r[0];
        else if (slot <= 16) b = l[16-slot];
        else b = r[32-slot];
        if (s.flip && (c % 16) >= 14) b = ~b;
        audio_sdin = b;
      end
      prev_r = r;
    end
    if (aborted) begin
      audio_lrck = 1'b1;
      audio_sdin = 1'b0;
      repeat (3) step();
      rst = 1'b0;
    end
    audio_lrck = 1'b1;
    audio_sdin = 1'b0;
    repeat ((s.n == 0) ? 2000 : 700) step();
    check("valid_count", 64'(valid_seen - vb), 64'(s.exp_valid));
    check("err_count", 64'(err_seen - eb), 64'(s.exp_err));
    check("queue_drained", 64'(exp_l.size()), 64'h0);
    check("unlocked_at_idle", {63'h0, locked}, 64'h0);
    if (s.n == 0)
      check("idle_outputs_zero", {31'h0, sample_left, sample_right, sample_valid}, 64'h0);
    exp_l.delete();
    exp_r.delete();
  endtask

  initial begin
    tbl[0] = '{1, 4, -1, -1, 1'b0, 3, 1};   // fixed 1234/ABCD loopback
    tbl[1] = '{2, 6, -1, -1, 1'b0, 5, 1};   // square wave, sign preserved
    tbl[2] = '{0, 6,  2, -1, 1'b0, 4, 2};   // frame 2 high phase stretched to 300
    tbl[3] = '{0, 0, -1, -1, 1'b0, 0, 0};   // lrck constant
    tbl[4] = '{0, 5, -1,  3, 1'b0, 3, 0};   // reset at slot 10 of frame 3
    tbl[5] = '{0, 5, -1, -1, 1'b1, 4, 1};   // sdin glitched in phases 14-15
    tbl[6] = '{0, 3, -1, -1, 1'b0, 2, 1};   // random short stream
    for (int i = 0; i < 7; i++) run_scenario(tbl[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
